// File: rtl/vector_order_deser.sv
// Serial-to-parallel word assembler (MSB- or LSB-first per word) feeding a DEPTH-entry output FIFO.
// out_valid rises one cycle after the completing bit; only the completing bit stalls when the FIFO is full.
module vector_order_deser #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sin_valid,
    input  logic                         sin_bit,
    output logic                         sin_ready,
    input  logic                         msb_first,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(WIDTH)-1:0]     bit_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               order_q, order_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic               eff_order;
    logic [CW-1:0]      pos;
    logic [WIDTH-1:0]   word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        sin_ready = !((bit_cnt_q == LAST_BIT) && (cnt_q == FULL_CNT)) && !flush;
        accept    = sin_valid && sin_ready;
        push      = accept && (bit_cnt_q == LAST_BIT);
        pop       = valid_q && out_ready;
        // The order is only open to change on the first bit of a word.
        eff_order = (state_q == S_IDLE) ? msb_first : order_q;
        pos       = eff_order ? (LAST_BIT - bit_cnt_q) : bit_cnt_q;
        word      = shreg_q;
        word[pos] = sin_bit;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        order_d   = order_q;
        if (flush) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (accept) begin
            order_d = eff_order;
            if (push) begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                state_d   = S_COLLECT;
                bit_cnt_d = bit_cnt_q + CW'(1);
                shreg_d   = word;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + FW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - FW'(1);
        end
        valid_d = (cnt_d != '0);
        head_d  = head_q;
        // Head is registered so out_data keeps the last word once the FIFO drains.
        if (cnt_d != '0) begin
            head_d = (push && (rd_ptr_d == wr_ptr_q)) ? word : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            order_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            order_q   <= order_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            if (push) begin
                mem_q[wr_ptr_q] <= word;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign bit_cnt   = bit_cnt_q;
    assign fifo_cnt  = cnt_q;

endmodule
